seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 11 +
 rtl/seg_hex_decode.sv | 10 +
 rtl/seg_scan_ctrl.sv | 99 +++++++++
 tb/tb_seg_scan_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment code table, blank code and digit-index width helper.
package seg_pkg;
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [7:0] SEG_BLANK = 8'h00;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: hex nibble plus decimal point to {dp,g,f,e,d,c,b,a}.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  assign seg = {dp, SEG_CODES[nib]};
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with tear-free data update.
// Define SEG_BLINK_EN to build the blink phase counter and honour blink_mask.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100_000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seg_data,
  output logic [NUM_DIGITS-1:0]   seg_cs,
  output logic                    frame_done
);
  localparam int IW = idx_w(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx, idx_n;
  logic [IW+1:0] nib_lo;
  logic run, tick, wrap, pending, blink_off;
  logic [4*NUM_DIGITS-1:0] shadow, active, act_n;
  logic [7:0] code, seg_n;
  assign tick   = enable && pcnt == PW'(SCAN_DIV - 1);
  assign wrap   = tick && run && idx == IW'(NUM_DIGITS - 1);
  assign idx_n  = (!run || wrap) ? '0 : idx + 1'b1;
  assign act_n  = (wrap && pending) ? shadow : active;
  assign nib_lo = {idx_n, 2'b00};
  assign seg_n  = (blank_mask[idx_n] || blink_off) ? SEG_BLANK : code;
  seg_hex_decode u_dec (.nib(act_n[nib_lo +: 4]), .dp(dp_mask[idx_n]), .seg(code));
  // run marks that a digit has been selected, so the first tick lands on digit 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
      idx <= '0;
      run <= 1'b0;
      seg_cs <= '0;
      seg_data <= SEG_BLANK;
      frame_done <= 1'b0;
    end else if (!enable) begin
      pcnt <= '0;
      idx <= '0;
      run <= 1'b0;
      seg_cs <= '0;
      seg_data <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      frame_done <= wrap;
      if (tick) begin
        idx <= idx_n;
        run <= 1'b1;
        seg_cs <= NUM_DIGITS'(1) << idx_n;
        seg_data <= seg_n;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      active <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= digit_data;
      pending <= load | (pending & ~wrap);
      active <= act_n;
    end
  end
`ifdef SEG_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] bcnt;
  logic phase, phase_n, blink_last;
  assign blink_last = wrap && bcnt == BW'(BLINK_FRAMES - 1);
  assign phase_n    = blink_last ? ~phase : phase;
  assign blink_off  = ~phase_n & blink_mask[idx_n];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt <= '0;
      phase <= 1'b1;
    end else if (!enable) begin
      bcnt <= '0;
      phase <= 1'b1;
    end else if (wrap) begin
      bcnt <= blink_last ? '0 : bcnt + 1'b1;
      phase <= phase_n;
    end
  end
`else
  logic unused_blink;
  assign blink_off    = 1'b0;
  assign unused_blink = (^blink_mask) ^ (BLINK_FRAMES > 0);
`endif
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench with a frame-arithmetic reference model.
module tb_seg_scan_ctrl;
  localparam int ND = 4, SD = 4, BF = 2;
  logic clk = 0, rst = 0, enable = 0, load = 0;
  logic [15:0] digit_data = '0;
  logic [3:0] dp_mask = '0, blank_mask = '0, blink_mask = '0;
  logic [7:0] seg_data;
  logic [3:0] seg_cs;
  logic frame_done;
  int checks = 0, errors = 0;
  logic [7:0] codes [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .digit_data(digit_data), .load(load),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .blink_mask(blink_mask),
    .seg_data(seg_data), .seg_cs(seg_cs), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: slot number and frame number follow from enabled cycle count.
  int ecnt = 0, s, d, fr;
  logic [15:0] m_sh = '0, m_act = '0, old_sh;
  logic m_pend = 0, old_p, tick, off;
  logic [3:0] e_cs = '0;
  logic [7:0] e_seg = '0;
  logic e_fd = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ecnt = 0; m_sh = '0; m_act = '0; m_pend = 0; e_cs = '0; e_seg = '0; e_fd = 0;
    end else begin
      old_sh = m_sh; old_p = m_pend; e_fd = 0;
      if (load) begin m_sh = digit_data; m_pend = 1; end
      if (!enable) begin
        ecnt = 0; e_cs = '0; e_seg = '0;
      end else begin
        tick = (ecnt % SD) == SD - 1;
        ecnt++;
        if (tick) begin
          s = ecnt / SD; d = (s - 1) % ND; fr = (s - 1) / ND;
          if (s > 1 && d == 0) begin
            e_fd = 1;
            if (old_p) begin m_act = old_sh; if (!load) m_pend = 0; end
          end
`ifdef SEG_BLINK_EN
          off = ((fr / BF) % 2 == 1) && blink_mask[d];
`else
          off = 0;
`endif
          e_cs = 4'(1 << d);
          e_seg = (blank_mask[d] || off) ? 8'h00 : {dp_mask[d], codes[m_act[4*d +: 4]][6:0]};
        end
      end
    end
  end
  always @(negedge clk) begin
    cmp("model_cs", {4'h0, seg_cs}, {4'h0, e_cs});
    cmp("model_seg", seg_data, e_seg);
    cmp("model_fd", {7'h0, frame_done}, {7'h0, e_fd});
  end
  task automatic wait_cs(input logic [3:0] t);
    int k = 0;
    do begin @(negedge clk); k++; end while (seg_cs !== t && k < 40);
    if (seg_cs !== t) cmp("wait_cs_timeout", {4'h0, seg_cs}, {4'h0, t});
  endtask
  initial begin
    repeat (3) @(negedge clk);
    cmp("rst_cs", {4'h0, seg_cs}, 8'h00);
    cmp("rst_seg", seg_data, 8'h00);
    cmp("rst_fd", {7'h0, frame_done}, 8'h00);
    rst = 1; enable = 1;
    repeat (4) @(negedge clk);
    cmp("first_cs", {4'h0, seg_cs}, 8'h01);
    cmp("first_seg", seg_data, 8'h3F);
    cmp("first_fd", {7'h0, frame_done}, 8'h00);
    for (int i = 1; i < 4; i++) begin
      repeat (4) @(negedge clk);
      cmp("scan_cs", {4'h0, seg_cs}, 8'(1 << i));
    end
    repeat (4) @(negedge clk);
    cmp("wrap_cs", {4'h0, seg_cs}, 8'h01);
    cmp("wrap_fd", {7'h0, frame_done}, 8'h01);
    @(negedge clk);
    cmp("wrap_fd_end", {7'h0, frame_done}, 8'h00);
    digit_data = 16'h1A90; load = 1;
    @(negedge clk); load = 0;
    wait_cs(4'b0010); cmp("old_d1", seg_data, 8'h3F);
    wait_cs(4'b0001); cmp("new_d0", seg_data, 8'h3F);
    wait_cs(4'b0010); cmp("new_d1", seg_data, 8'h6F);
    wait_cs(4'b0100); cmp("new_d2", seg_data, 8'h77);
    wait_cs(4'b1000); cmp("new_d3", seg_data, 8'h06);
    digit_data = 16'h1111; load = 1;
    @(negedge clk); load = 0;
    repeat (2) @(negedge clk);
    digit_data = 16'h2222; load = 1;
    @(negedge clk); load = 0;
    cmp("coinc_cs", {4'h0, seg_cs}, 8'h01);
    cmp("coinc_d0", seg_data, 8'h06);
    wait_cs(4'b0010); cmp("coinc_d1", seg_data, 8'h06);
    wait_cs(4'b0001); cmp("next_d0", seg_data, 8'h5B);
    wait_cs(4'b0010); cmp("next_d1", seg_data, 8'h5B);
    @(negedge clk); enable = 0;
    @(negedge clk);
    cmp("dis_cs", {4'h0, seg_cs}, 8'h00);
    cmp("dis_seg", seg_data, 8'h00);
    repeat (3) @(negedge clk);
    blink_mask = 4'b0010; dp_mask = 4'b0001; enable = 1;
    for (int f = 1; f <= 6; f++) begin
      wait_cs(4'b0001); cmp("blink_d0", seg_data, 8'hDB);
      wait_cs(4'b0010);
`ifdef SEG_BLINK_EN
      cmp("blink_d1", seg_data, (f == 3 || f == 4) ? 8'h00 : 8'h5B);
`else
      cmp("blink_d1", seg_data, 8'h5B);
`endif
    end
    wait_cs(4'b0100);
    #2 rst = 0;
    #1;
    cmp("arst_cs", {4'h0, seg_cs}, 8'h00);
    cmp("arst_seg", seg_data, 8'h00);
    cmp("arst_fd", {7'h0, frame_done}, 8'h00);
    @(negedge clk); #2 rst = 1;
    wait_cs(4'b0001); cmp("post_rst_d0", seg_data, 8'hBF);
    wait_cs(4'b0010); cmp("post_rst_d1", seg_data, 8'h3F);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
